mips_debug_ctrl: RTL and testbench
==================================

Name: mips_debug_ctrl

Overview:
Host-facing controller that sequences the instruction-fetch stage and pipeline from a UART byte stream.
- Loads program words into instruction memory through the fetch stage write port.
- Runs the pipeline continuously or steps it one cycle at a time.
- Freezes the pipeline on halt and reports the halted PC back over the UART transmit path.
- Sits between the UART rx/tx pair and the pipeline top.

Parameters:
DATA_W, 32, instruction/PC width
BYTE_W, 8, UART byte width
CNT_W, 8, width of load word-count field (0 encodes 2^CNT_W)

Ports:
clk  in  1  system clock, rising edge
i_rst  in  1  reset; one clock; reset is synchronous and active-high
i_rx_data  in  BYTE_W  received byte
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
i_tx_ready  in  1  transmitter accepts o_tx_data this cycle
i_pc  in  DATA_W  current fetch PC from pipeline
i_halt_detected  in  1  HALT instruction retired (level or pulse)
o_tx_data  out  BYTE_W  byte to transmit
o_tx_valid  out  1  o_tx_data valid, held until accepted
o_we  out  1  instruction-memory write strobe to fetch stage
o_instr_data  out  DATA_W  word to write
o_halt  out  1  freeze pipeline (1 = frozen)
o_pipe_rst  out  1  one-cycle pipeline/write-pointer reset request
o_state  out  3  current FSM state, for debug

Behaviour:
- Reset values: state IDLE, o_halt=1, o_we=0, o_instr_data=0, o_tx_valid=0, o_tx_data=0, o_pipe_rst=0, counters 0.
- Command bytes: L=0x4C load, R=0x52 run, S=0x53 step, P=0x50 report PC, H=0x48 force halt.
- Any other byte in IDLE is ignored.
- IDLE:
  - L: o_pipe_rst=1 for the following cycle, then go to LOAD_CNT.
  - R: go to RUN.
  - S: go to STEP.
  - P: latch i_pc, go to REPORT.
- LOAD_CNT:
  - Next rx byte is N; 0 means 256 words.
  - Load remaining-word counter, clear byte index, go to LOAD_WORD.
- LOAD_WORD:
  - Bytes assembled MSB first into a shift register.
  - On the 4th byte: o_instr_data = assembled word and o_we=1 for exactly one cycle (the cycle after the 4th strobe); decrement counter.
  - When counter reaches 0 after a write, go to IDLE.
  - o_halt stays 1 throughout loading.
- RUN:
  - o_halt=0 starting the cycle after entry.
  - i_halt_detected=1, or rx byte H: next cycle o_halt=1, latch i_pc, go to REPORT.
  - Other rx bytes in RUN are dropped.
- STEP:
  - o_halt=0 for exactly one cycle, then o_halt=1.
  - Latch i_pc the cycle after release, go to REPORT.
  - i_halt_detected during STEP is recorded only as a normal halt.
- REPORT:
  - Send 4 bytes of the latched PC, MSB first.
  - o_tx_valid held high with o_tx_data stable until i_tx_ready.
  - Byte index advances only on valid && ready.
  - After the 4th accepted byte, o_tx_valid=0 and go to IDLE.
  - rx bytes during REPORT are dropped.
- Simultaneous events:
  - o_we and o_pipe_rst are never asserted in the same cycle.
  - Halt has priority over H in RUN (both produce one report, not two).
- Reset mid-operation (any state): immediate return to reset values next cycle.
  - A partial word is discarded and no o_we is issued.
  - An in-flight tx byte is abandoned (o_tx_valid drops).
- Width rules:
  - Word counter is CNT_W+1 bits, to hold 256.
  - Byte index is 2 bits and wraps 3->0.

Decomposition:
- Package mips_debug_pkg holds:
  - command byte constants CMD_LOAD, CMD_RUN, CMD_STEP, CMD_PC, CMD_HALT;
  - FSM state encoding IDLE=0, LOAD_CNT=1, LOAD_WORD=2, RUN=3, STEP=4, REPORT=5;
  - BYTES_PER_WORD=4.
- One natural sub-module, debug_word_serdes: 4-byte MSB-first assembler and serializer, shared by the LOAD_WORD and REPORT paths.

Test Plan:
- Load path: reset, send 4C 02 88 88 88 88 FF FF FF FF -> one o_pipe_rst pulse; o_we pulses twice with 0x88888888 then 0xFFFFFFFF; state returns to IDLE; o_halt stays 1 throughout.
- Run and report: send 52; pulse i_halt_detected with i_pc=0x00000040 -> o_halt falls, then rises the cycle after halt; tx bytes 00 00 00 40 in order; o_tx_valid held across i_tx_ready=0 gaps of 3 cycles.
- Step: send 53 with i_pc=0x0C -> o_halt low for exactly 1 cycle; report 00 00 00 10 when the PC advanced by 4.
- Force halt and dropped bytes: in RUN send 41 then 48 -> 41 ignored; halt and report follow the 48.
- Reset mid-load: send 4C 01 AA AA, assert i_rst -> no o_we; outputs at reset values; subsequent 50 reports the current PC.
- Boundary: count byte 00 -> exactly 256 o_we pulses, then IDLE; unknown byte 7E in IDLE -> no output change.

Source files
------------

// File: rtl/mips_debug_pkg.sv
// Shared constants for the MIPS debug controller: host command bytes, FSM
// state encoding and word framing.
package mips_debug_pkg;

   localparam int BYTES_PER_WORD = 4;

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_RUN  = 8'h52;
   localparam logic [7:0] CMD_STEP = 8'h53;
   localparam logic [7:0] CMD_PC   = 8'h50;
   localparam logic [7:0] CMD_HALT = 8'h48;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_CNT  = 3'd1,
      LOAD_WORD = 3'd2,
      RUN       = 3'd3,
      STEP      = 3'd4,
      REPORT    = 3'd5
   } state_t;

   function automatic logic is_last_byte(input logic [1:0] idx);
      return idx == 2'(BYTES_PER_WORD - 1);
   endfunction

endpackage

// File: rtl/debug_word_serdes.sv
// Four-byte MSB-first word assembler / serializer. A single shift register
// collects incoming load bytes and shifts out the latched PC during reports.
module debug_word_serdes
   import mips_debug_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_word,
   input  logic              i_shift,
   input  logic [BYTE_W-1:0] i_byte,
   output logic [DATA_W-1:0] o_word_next,
   output logic [BYTE_W-1:0] o_byte,
   output logic              o_last
);

   logic [DATA_W-1:0] sreg;
   logic [1:0]        idx;

   // Word as it will look once i_byte is shifted in; also the write data on the 4th byte.
   assign o_word_next = {sreg[DATA_W-BYTE_W-1:0], i_byte};
   assign o_byte      = sreg[DATA_W-1 -: BYTE_W];
   assign o_last      = is_last_byte(idx);

   always_ff @(posedge clk) begin
      if (i_rst) begin
         // NOTE: the shift register is reset too, so a partial word never survives a reset.
         sreg <= '0;
         idx  <= '0;
      end else if (i_load) begin
         sreg <= i_word;
         idx  <= '0;
      end else if (i_clear) begin
         idx  <= '0;
      end else if (i_shift) begin
         sreg <= o_word_next;
         idx  <= idx + 2'd1;
      end
   end

endmodule

// File: rtl/mips_debug_ctrl.sv
// Host-facing debug controller: decodes UART command bytes to load program
// words, run or single-step the pipeline, and report the halted PC.
module mips_debug_ctrl
   import mips_debug_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int BYTE_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              i_rst,
   input  logic [BYTE_W-1:0] i_rx_data,
   input  logic              i_rx_valid,
   input  logic              i_tx_ready,
   input  logic [DATA_W-1:0] i_pc,
   input  logic              i_halt_detected,
   output logic [BYTE_W-1:0] o_tx_data,
   output logic              o_tx_valid,
   output logic              o_we,
   output logic [DATA_W-1:0] o_instr_data,
   output logic              o_halt,
   output logic              o_pipe_rst,
   output logic [2:0]        o_state
);

   localparam logic [CNT_W:0] CNT_ONE = 1;

   state_t            state_q, state_d;
   logic [CNT_W:0]    cnt_q, cnt_d;
   logic              released_q, released_d;
   logic              halt_d, we_d, pipe_rst_d;
   logic [DATA_W-1:0] instr_d;

   logic              ser_clear, ser_load, ser_shift, ser_last;
   logic [DATA_W-1:0] ser_word_next;
   logic [BYTE_W-1:0] ser_byte;

   debug_word_serdes #(
      .DATA_W (DATA_W),
      .BYTE_W (BYTE_W)
   ) u_serdes (
      .clk         (clk),
      .i_rst       (i_rst),
      .i_clear     (ser_clear),
      .i_load      (ser_load),
      .i_word      (i_pc),
      .i_shift     (ser_shift),
      .i_byte      (i_rx_data),
      .o_word_next (ser_word_next),
      .o_byte      (ser_byte),
      .o_last      (ser_last)
   );

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         o_halt       <= 1'b1;
         o_we         <= 1'b0;
         o_instr_data <= '0;
         o_pipe_rst   <= 1'b0;
         cnt_q        <= '0;
         released_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         o_halt       <= halt_d;
         o_we         <= we_d;
         o_instr_data <= instr_d;
         o_pipe_rst   <= pipe_rst_d;
         cnt_q        <= cnt_d;
         released_q   <= released_d;
      end
   end

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_d    = state_q;
      halt_d     = o_halt;
      we_d       = 1'b0;
      pipe_rst_d = 1'b0;
      instr_d    = o_instr_data;
      cnt_d      = cnt_q;
      released_d = released_q;
      ser_clear  = 1'b0;
      ser_load   = 1'b0;
      ser_shift  = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_rx_valid) begin
               case (i_rx_data)
                  CMD_LOAD: begin
                     pipe_rst_d = 1'b1;
                     state_d    = LOAD_CNT;
                  end
                  CMD_RUN:  state_d = RUN;
                  CMD_STEP: state_d = STEP;
                  CMD_PC: begin
                     ser_load = 1'b1;
                     state_d  = REPORT;
                  end
                  default: ;
               endcase
            end
         end

         LOAD_CNT: begin
            if (i_rx_valid) begin
               // A count byte of zero stands for the full 2^CNT_W words.
               if (i_rx_data[CNT_W-1:0] == '0) cnt_d = {1'b1, {CNT_W{1'b0}}};
               else                            cnt_d = {1'b0, i_rx_data[CNT_W-1:0]};
               ser_clear = 1'b1;
               state_d   = LOAD_WORD;
            end
         end

         LOAD_WORD: begin
            if (i_rx_valid) begin
               ser_shift = 1'b1;
               if (ser_last) begin
                  we_d    = 1'b1;
                  instr_d = ser_word_next;
                  cnt_d   = cnt_q - CNT_ONE;
                  if (cnt_q == CNT_ONE) state_d = IDLE;
               end
            end
         end

         RUN: begin
            // A retired HALT and a host H in the same cycle collapse into one report.
            if (i_halt_detected || (i_rx_valid && i_rx_data == CMD_HALT)) begin
               halt_d   = 1'b1;
               ser_load = 1'b1;
               state_d  = REPORT;
            end else begin
               halt_d = 1'b0;
            end
         end

         STEP: begin
            // Release for one cycle, refreeze, then sample the advanced PC.
            if (!released_q) begin
               halt_d     = 1'b0;
               released_d = 1'b1;
            end else if (!o_halt) begin
               halt_d = 1'b1;
            end else begin
               ser_load   = 1'b1;
               released_d = 1'b0;
               state_d    = REPORT;
            end
         end

         REPORT: begin
            if (i_tx_ready) begin
               ser_shift = 1'b1;
               if (ser_last) state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign o_tx_valid = (state_q == REPORT);
   assign o_tx_data  = o_tx_valid ? ser_byte : '0;
   assign o_state    = state_q;

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Self-checking bench for mips_debug_ctrl: directed scenarios plus randomized
// commands, with a bench-side pipeline PC model and expected-result queues.
module tb_mips_debug_ctrl;

   logic        clk = 1'b0;
   logic        i_rst;
   logic [7:0]  i_rx_data;
   logic        i_rx_valid;
   logic        i_tx_ready;
   logic [31:0] i_pc;
   logic        i_halt_detected;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        o_we;
   logic [31:0] o_instr_data;
   logic        o_halt;
   logic        o_pipe_rst;
   logic [2:0]  o_state;

   always #5 clk = ~clk;

   mips_debug_ctrl dut (
      .clk             (clk),
      .i_rst           (i_rst),
      .i_rx_data       (i_rx_data),
      .i_rx_valid      (i_rx_valid),
      .i_tx_ready      (i_tx_ready),
      .i_pc            (i_pc),
      .i_halt_detected (i_halt_detected),
      .o_tx_data       (o_tx_data),
      .o_tx_valid      (o_tx_valid),
      .o_we            (o_we),
      .o_instr_data    (o_instr_data),
      .o_halt          (o_halt),
      .o_pipe_rst      (o_pipe_rst),
      .o_state         (o_state)
   );

   localparam logic [31:0] ST_IDLE = 0, ST_RUN = 3, ST_REPORT = 5;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] we_obs[$];
   logic [31:0] exp_we[$];
   logic [7:0]  tx_obs[$];
   int          halt_runs[$];
   int          prst_cnt = 0;
   int          overlap_cnt = 0;
   int          stab_err = 0;
   int          low_len = 0;
   int          cyc = 0;
   bit          tx_gap_mode = 1'b0;
   bit          ready_off = 1'b0;
   bit          prev_pending = 1'b0;
   logic [7:0]  prev_tx = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Observe the current cycle, advance one clock, then update the pipeline model.
   task automatic tick();
      logic halt_now;
      if (o_we === 1'b1) we_obs.push_back(o_instr_data);
      if (o_pipe_rst === 1'b1) prst_cnt++;
      if (o_we === 1'b1 && o_pipe_rst === 1'b1) overlap_cnt++;
      if (prev_pending && !(o_tx_valid === 1'b1 && o_tx_data === prev_tx)) stab_err++;
      prev_pending = (o_tx_valid === 1'b1) && !i_tx_ready && !i_rst;
      prev_tx      = o_tx_data;
      if (o_tx_valid === 1'b1 && i_tx_ready && !i_rst) tx_obs.push_back(o_tx_data);
      if (o_halt === 1'b0) low_len++;
      else if (low_len > 0) begin
         halt_runs.push_back(low_len);
         low_len = 0;
      end
      halt_now = o_halt;
      @(negedge clk);
      cyc++;
      if (halt_now === 1'b0) i_pc += 32'd4;
      i_tx_ready = ready_off ? 1'b0 : (tx_gap_mode ? (cyc % 4 == 0) : 1'($urandom_range(0, 1)));
   endtask

   task automatic send(input logic [7:0] b);
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
      i_rx_data  = 8'($urandom);
      tick();
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 3; k >= 0; k--) send(w[8*k +: 8]);
   endtask

   task automatic load_random(input logic [7:0] count_byte);
      int          n;
      logic [31:0] w;
      n = (count_byte == 8'd0) ? 256 : int'(count_byte);
      exp_we.delete();
      we_obs.delete();
      send(8'h4C);
      send(count_byte);
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         exp_we.push_back(w);
         send_word(w);
      end
      tick();
   endtask

   task automatic check_writes(input string tag);
      check({tag, " count"}, we_obs.size(), exp_we.size());
      for (int i = 0; i < exp_we.size() && i < we_obs.size(); i++)
         check($sformatf("%s[%0d]", tag, i), we_obs[i], exp_we[i]);
   endtask

   task automatic expect_report(input string tag, input logic [31:0] exp);
      bit          ok;
      logic [31:0] got;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (o_state === 3'd0 && tx_obs.size() >= 4) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check({tag, " done"}, 32'(ok), 32'd1);
      check({tag, " nbytes"}, tx_obs.size(), 4);
      got = (tx_obs.size() >= 4) ? {tx_obs[0], tx_obs[1], tx_obs[2], tx_obs[3]} : 'x;
      check({tag, " pc"}, got, exp);
      tx_obs.delete();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " state"},    o_state,      ST_IDLE);
      check({tag, " halt"},     o_halt,       1);
      check({tag, " we"},       o_we,         0);
      check({tag, " instr"},    o_instr_data, 0);
      check({tag, " tx_valid"}, o_tx_valid,   0);
      check({tag, " tx_data"},  o_tx_data,    0);
      check({tag, " pipe_rst"}, o_pipe_rst,   0);
   endtask

   initial begin
      logic [31:0] exp_pc;
      logic [47:0] snap;
      int          p0;
      int          run0;

      i_rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = '0; i_tx_ready = 1'b1;
      i_pc = '0; i_halt_detected = 1'b0;
      @(negedge clk);
      tick();
      tick();
      i_rst = 1'b0;
      check_reset_values("reset");
      we_obs.delete(); tx_obs.delete(); halt_runs.delete(); prst_cnt = 0;

      // Directed load of two words.
      exp_we.delete();
      exp_we.push_back(32'h8888_8888);
      exp_we.push_back(32'hFFFF_FFFF);
      send(8'h4C);
      send(8'h02);
      send_word(32'h8888_8888);
      send_word(32'hFFFF_FFFF);
      tick();
      check_writes("load2");
      check("load2 pipe_rst", prst_cnt, 1);
      check("load2 state", o_state, ST_IDLE);
      check("load2 halt_runs", halt_runs.size(), 0);

      // Run, then retire HALT at PC 0x40 with 3-cycle ready gaps.
      tx_gap_mode = 1'b1;
      send(8'h52);
      check("run halt_low", o_halt, 0);
      repeat (3) tick();
      i_pc = 32'h40;
      i_halt_detected = 1'b1;
      tick();
      i_halt_detected = 1'b0;
      check("run halt_high", o_halt, 1);
      check("run state_report", o_state, ST_REPORT);
      expect_report("run_report", 32'h40);
      tx_gap_mode = 1'b0;

      // Single step from 0x0C.
      halt_runs.delete();
      i_pc = 32'h0C;
      send(8'h53);
      expect_report("step_report", 32'h10);
      check("step runs", halt_runs.size(), 1);
      check("step low_len", (halt_runs.size() > 0) ? halt_runs[0] : 0, 1);

      // Force halt; unrelated byte in RUN dropped.
      send(8'h52);
      send(8'h41);
      check("drop41 state", o_state, ST_RUN);
      check("drop41 halt", o_halt, 0);
      exp_pc = i_pc;
      send(8'h48);
      expect_report("force_halt", exp_pc);

      // HALT and H together yield a single report.
      send(8'h52);
      tick();
      exp_pc = i_pc;
      i_halt_detected = 1'b1; i_rx_valid = 1'b1; i_rx_data = 8'h48;
      tick();
      i_halt_detected = 1'b0; i_rx_valid = 1'b0;
      expect_report("halt_and_h", exp_pc);
      repeat (12) tick();
      check("halt_and_h extra", tx_obs.size(), 0);
      check("halt_and_h idle", o_state, ST_IDLE);

      // Reset in the middle of a word.
      we_obs.delete();
      send(8'h4C); send(8'h01); send(8'hAA); send(8'hAA);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check_reset_values("midload");
      send(8'hAA); send(8'hAA);
      check("midload no_we", we_obs.size(), 0);
      i_pc = 32'h1234_5678;
      send(8'h50);
      expect_report("pc_after_rst", 32'h1234_5678);

      // Reset while a tx byte is pending.
      ready_off = 1'b1; i_tx_ready = 1'b0;
      send(8'h50);
      check("midtx valid", o_tx_valid, 1);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check("midtx dropped", o_tx_valid, 0);
      check("midtx data", o_tx_data, 0);
      check("midtx state", o_state, ST_IDLE);
      ready_off = 1'b0;
      tx_obs.delete();

      // Unknown command changes nothing.
      snap = {5'd0, o_state, o_halt, o_we, o_tx_valid, o_pipe_rst, o_tx_data, o_instr_data};
      send(8'h7E);
      check("unknown hi", {5'd0, o_state, o_halt, o_we, o_tx_valid, o_pipe_rst, o_tx_data}, snap[47:32]);
      check("unknown lo", o_instr_data, snap[31:0]);

      // Count byte zero means 256 words.
      p0 = prst_cnt;
      load_random(8'h00);
      check_writes("load256");
      check("load256 state", o_state, ST_IDLE);
      check("load256 pipe_rst", prst_cnt - p0, 1);

      // Randomized command mix.
      for (int it = 0; it < 8; it++) begin
         case ($urandom_range(0, 3))
            0: begin
               p0 = prst_cnt;
               load_random(8'($urandom_range(1, 3)));
               check_writes("rnd_load");
               check("rnd_load pipe_rst", prst_cnt - p0, 1);
            end
            1: begin
               i_pc = $urandom;
               exp_pc = i_pc;
               send(8'h50);
               expect_report("rnd_pc", exp_pc);
            end
            2: begin
               send(8'h52);
               repeat ($urandom_range(0, 6)) tick();
               i_pc = $urandom;
               exp_pc = i_pc;
               i_halt_detected = 1'b1;
               tick();
               i_halt_detected = 1'b0;
               expect_report("rnd_run", exp_pc);
            end
            default: begin
               halt_runs.delete();
               i_pc = $urandom & 32'hFFFF_FFFC;
               exp_pc = i_pc + 32'd4;
               send(8'h53);
               expect_report("rnd_step", exp_pc);
               run0 = (halt_runs.size() > 0) ? halt_runs[0] : 0;
               check("rnd_step low_len", run0, 1);
            end
         endcase
      end

      check("we_pipe_rst overlap", overlap_cnt, 0);
      check("tx hold stable", stab_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
